alu_share_arbiter: RTL and testbench

- Shares one instance of the core's combinational ALU between NUM_REQ requesters (e.g. audio DSP lanes, address-gen unit).
- Round-robin arbitration with valid/ready request channels.
- Two-stage registered pipeline: operand register, then result register.
- A single response channel with backpressure returns results tagged with the requester ID.
- Sustains one operation per cycle when the response channel is not stalled.

---
 rtl/alu_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Round-robin arbitration feeds an operand register (S1) whose outputs drive
// the ALU; the ALU result is captured in a result register (S2) that forms the
// response channel. Both stages advance independently so one op per cycle
// flows through when the response consumer is not stalling.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]    req_ctrl,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [3:0]              alu_ctrl,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero
);

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;
  logic [3:0]      s1_ctrl_q, s1_ctrl_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [31:0]     s2_result_q, s2_result_d;
  logic            s2_zero_q, s2_zero_d;
  logic            s2_err_q, s2_err_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            s2_adv;
  logic            s1_adv;
  logic            any_valid;
  logic            grant;
  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   cand;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [3:0]      sel_ctrl;

  // Opcodes the shared ALU does not implement; it returns 0 for these.
  function automatic logic ctrl_illegal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign s2_adv    = !s2_valid_q || resp_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign any_valid = |req_valid;
  assign grant     = s1_adv && any_valid;

  // Pick the first valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  // Accept only the winner, and only when stage 1 can take a new op.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Steer the winner's operands and opcode toward stage 1.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
        sel_ctrl = req_ctrl[4*i +: 4];
      end
    end
  end

  // Next-state for both pipeline stages and the round-robin pointer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_id_d     = s1_id_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_err_d    = s2_err_q;
    s2_id_d     = s2_id_q;
    rr_ptr_d    = rr_ptr_q;

    if (s1_adv) begin
      s1_valid_d = grant;
      if (grant) begin
        s1_a_d    = sel_a;
        s1_b_d    = sel_b;
        s1_ctrl_d = sel_ctrl;
        s1_id_d   = winner;
      end
    end

    if (grant) begin
      rr_ptr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = alu_result;
        s2_zero_d   = alu_zero;
        s2_err_d    = ctrl_illegal(s1_ctrl_q);
        s2_id_d     = s1_id_q;
      end
    end
  end

  // Pipeline and pointer registers; reset drops every in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ctrl_q   <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_id_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_err_q    <= s2_err_d;
      s2_id_q     <= s2_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign alu_a       = s1_a_q;
  assign alu_b       = s1_b_q;
  assign alu_ctrl    = s1_ctrl_q;
  assign resp_valid  = s2_valid_q;
  assign resp_id     = s2_id_q;
  assign resp_result = s2_result_q;
  assign resp_zero   = s2_zero_q;
  assign resp_err    = s2_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: drives randomized and directed traffic into the
// shared-ALU arbiter and compares every cycle against a transaction-level
// model (queue of in-flight ops, grant-order delivery, two-cycle latency).
module tb_alu_share_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [15:0]  req_ctrl;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_zero;
  logic         resp_err;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [3:0]   alu_ctrl;
  logic [31:0]  alu_result;
  logic         alu_zero;

  int errors = 0;
  int checks = 0;

  // Staged stimulus, copied onto the DUT inputs just after each rising edge.
  logic [3:0]  st_valid;
  logic [31:0] st_a [4];
  logic [31:0] st_b [4];
  logic [3:0]  st_ctrl [4];
  logic        st_rr;
  logic        st_rst;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    int          cyc;
  } op_t;

  op_t q[$];
  int  now = 0;
  int  ptr = 0;
  bit  m_grant;
  bit  m_fire;
  int  m_w;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ctrl    (req_ctrl),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Reference arithmetic of the shared ALU; unsupported opcodes give 0.
  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit isLegal(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6) || (c == 4'd7) || (c == 4'd8);
  endfunction

  function automatic int pickWinner(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Combinational ALU stand-in connected to the DUT's ALU port.
  always_comb begin
    alu_result = aluModel(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, now, act, exp);
    end
  endtask

  task automatic setLane(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    st_a[i]    = a;
    st_b[i]    = b;
    st_ctrl[i] = c;
  endtask

  task automatic applyStimulus();
    req_valid  = st_valid;
    resp_ready = st_rr;
    rst        = st_rst;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32]  = st_a[i];
      req_b[32*i +: 32]  = st_b[i];
      req_ctrl[4*i +: 4] = st_ctrl[i];
    end
  endtask

  // Compare DUT outputs with what the transaction model says this cycle.
  task automatic checkOutput();
    bit          exp_valid;
    logic [31:0] res;
    logic [3:0]  exp_ready;
    bit          room;
    exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= now);
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      res = aluModel(q[0].a, q[0].b, q[0].ctrl);
      chk("resp_id", 32'(resp_id), 32'(q[0].id));
      chk("resp_result", resp_result, res);
      chk("resp_zero", 32'(resp_zero), 32'(res == 32'd0));
      chk("resp_err", 32'(resp_err), 32'(!isLegal(q[0].ctrl)));
    end
    room      = (q.size() < 2) || (resp_ready == 1'b1);
    m_w       = pickWinner(ptr, req_valid);
    m_grant   = room && (m_w >= 0);
    exp_ready = m_grant ? (4'b0001 << m_w) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    m_fire = exp_valid && (resp_ready == 1'b1);
  endtask

  task automatic modelStep();
    op_t op;
    if (st_rst) begin
      q.delete();
      ptr = 0;
    end else begin
      if (m_fire) void'(q.pop_front());
      if (m_grant) begin
        op.id   = 2'(m_w);
        op.a    = st_a[m_w];
        op.b    = st_b[m_w];
        op.ctrl = st_ctrl[m_w];
        op.cyc  = now;
        q.push_back(op);
        ptr = (m_w + 1) % 4;
      end
    end
    now++;
  endtask

  task automatic runCycle(input logic [3:0] v, input logic rr, input logic r);
    st_valid = v;
    st_rr    = rr;
    st_rst   = r;
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    modelStep();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) setLane(i, 32'd0, 32'd0, 4'd0);
    st_valid = 4'd0;
    st_rr    = 1'b1;
    st_rst   = 1'b1;
    applyStimulus();

    // Reset state
    runCycle(4'b0000, 1'b1, 1'b1);
    runCycle(4'b0000, 1'b1, 1'b1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_zero", 32'(resp_zero), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    runCycle(4'b0000, 1'b1, 1'b0);

    // Round-robin with all requesters valid, MUL by 10
    for (int i = 0; i < 4; i++) setLane(i, 32'(i + 1), 32'd10, 4'b1000);
    for (int k = 0; k < 12; k++) begin
      runCycle((k < 8) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);
      if (k < 8) chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2 && k < 10) begin
        chk("rr_valid", 32'(resp_valid), 32'd1);
        chk("rr_id", 32'(resp_id), 32'((k - 2) % 4));
        chk("rr_result", resp_result, 32'(10 * ((k - 2) % 4 + 1)));
      end
    end

    // Single op: 7 + 5 from requester 0
    setLane(0, 32'd7, 32'd5, 4'b0010);
    runCycle(4'b0001, 1'b1, 1'b0);
    chk("single_ready", 32'(req_ready), 32'b0001);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("single_early", 32'(resp_valid), 32'd0);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_id", 32'(resp_id), 32'd0);
    chk("single_result", resp_result, 32'd12);
    chk("single_zero", 32'(resp_zero), 32'd0);
    chk("single_err", 32'(resp_err), 32'd0);

    // Zero flag: SUB 5-5 then SLT 3<9 from requester 2
    setLane(2, 32'd5, 32'd5, 4'b0110);
    runCycle(4'b0100, 1'b1, 1'b0);
    setLane(2, 32'd3, 32'd9, 4'b0111);
    runCycle(4'b0100, 1'b1, 1'b0);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("zf_id", 32'(resp_id), 32'd2);
    chk("zf_result", resp_result, 32'd0);
    chk("zf_zero", 32'(resp_zero), 32'd1);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("slt_result", resp_result, 32'd1);
    chk("slt_zero", 32'(resp_zero), 32'd0);

    // Illegal opcode followed by a legal one from requester 3
    setLane(3, 32'd1, 32'd1, 4'b1111);
    runCycle(4'b1000, 1'b1, 1'b0);
    setLane(3, 32'd1, 32'd1, 4'b0010);
    runCycle(4'b1000, 1'b1, 1'b0);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("ill_id", 32'(resp_id), 32'd3);
    chk("ill_result", resp_result, 32'd0);
    chk("ill_zero", 32'(resp_zero), 32'd1);
    chk("ill_err", 32'(resp_err), 32'd1);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("post_ill_err", 32'(resp_err), 32'd0);
    chk("post_ill_result", resp_result, 32'd2);

    // Backpressure: requester 1 streams ADD k+100 while resp_ready drops
    for (int k = 0; k < 8; k++) begin
      setLane(1, 32'(k), 32'd100, 4'b0010);
      runCycle(4'b0010, (k >= 2 && k <= 4) ? 1'b0 : 1'b1, 1'b0);
      if (k >= 3 && k <= 4) begin
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_valid", 32'(resp_valid), 32'd1);
        chk("bp_id", 32'(resp_id), 32'd1);
        chk("bp_result", resp_result, 32'd100);
      end
    end
    for (int k = 0; k < 4; k++) runCycle(4'b0000, 1'b1, 1'b0);

    // Reset mid-flight, then contention between requesters 0 and 2
    setLane(0, 32'd4, 32'd4, 4'b0010);
    setLane(1, 32'd6, 32'd6, 4'b0010);
    setLane(2, 32'd8, 32'd8, 4'b0010);
    runCycle(4'b0001, 1'b1, 1'b0);
    runCycle(4'b0010, 1'b1, 1'b1);
    runCycle(4'b0101, 1'b1, 1'b0);
    chk("mr_ready", 32'(req_ready), 32'b0001);
    chk("mr_valid0", 32'(resp_valid), 32'd0);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("mr_valid1", 32'(resp_valid), 32'd0);
    runCycle(4'b0000, 1'b1, 1'b0);
    chk("mr_valid2", 32'(resp_valid), 32'd1);
    chk("mr_id", 32'(resp_id), 32'd0);
    chk("mr_result", resp_result, 32'd8);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [3:0] ops [6];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000};
      for (int i = 0; i < 4; i++) begin
        setLane(i,
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom()),
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom()),
                ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                            : ops[$urandom_range(0, 5)]);
      end
      runCycle(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
